// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM states, parity encodings, oversample timing.
// Parity helper returns the expected parity bit for a data word.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam int         OVS      = 16;
  localparam logic [3:0] MID      = 4'd7;

  // Odd parity is any encoding with bit0 set.
  function automatic logic par_expected(input logic [7:0] d, input logic [1:0] ptype);
    return ptype[0] ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clocks, restartable on a start edge.
// Tick is combinational from the counter (zero latency); no backpressure.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled; data_valid pulses ~(1.5 + bits) bit times after the start edge.
// No backpressure: data_out/error flags hold until the next frame. Macro UART_RX_MAJORITY_EN enables 3-sample voting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       data_length,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy
);

  localparam logic [3:0] LAST = 4'(OVS - 1);

  logic       rx_s1, rx_s2, rx_prev;
  logic [1:0] hist;
  state_t     state;
  logic [3:0] smp_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       len8_l;
  logic [1:0] pt_l;
  logic       perr_r;
  logic       tick, fall, restart, bit_val;

  assign fall    = rx_prev & ~rx_s2;
  assign restart = (state == IDLE) && fall;

`ifdef UART_RX_MAJORITY_EN
  // Start decision moves one tick later so the vote covers counts 6, 7 and 8;
  // every later bit keeps the same 16-tick spacing and therefore the same window.
  localparam logic [3:0] START_DEC = MID + 4'd1;
  assign bit_val = (hist[0] & hist[1]) | (hist[0] & rx_s2) | (hist[1] & rx_s2);
`else
  localparam logic [3:0] START_DEC = MID;
  assign bit_val = rx_s2;
`endif

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      hist         <= 2'b11;
      state        <= IDLE;
      smp_cnt      <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      len8_l       <= 1'b0;
      pt_l         <= PAR_NONE;
      perr_r       <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_s1      <= rx_in;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      data_valid <= 1'b0;
      if (tick) hist <= {hist[0], rx_s2};

      case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            smp_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            perr_r  <= 1'b0;
            len8_l  <= data_length;
            pt_l    <= parity_type;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (smp_cnt == START_DEC) begin
              smp_cnt <= '0;
              if (bit_val) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              smp_cnt <= smp_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            smp_cnt <= smp_cnt + 4'd1;
            if (smp_cnt == LAST) begin
              shreg[bit_idx] <= bit_val;
              bit_idx        <= bit_idx + 3'd1;
              if (bit_idx == (len8_l ? 3'd7 : 3'd6))
                state <= (pt_l != PAR_NONE) ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            smp_cnt <= smp_cnt + 4'd1;
            if (smp_cnt == LAST) begin
              perr_r <= (bit_val != par_expected(shreg, pt_l));
              state  <= STOP;
            end
          end
        end
        STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (tick) begin
            smp_cnt <= smp_cnt + 4'd1;
            if (smp_cnt == LAST) begin
              data_out     <= shreg;
              parity_error <= perr_r & (pt_l != PAR_NONE);
              frame_error  <= ~bit_val;
              data_valid   <= 1'b1;
              state        <= IDLE;
              busy         <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=4 (64 clk per bit): directed cases plus random frames
// checked against a frame-level reference model.
module tb_uart_rx;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic       data_length = 1'b1;
  logic [1:0] parity_type = 2'b00;
  logic [7:0] data_out;
  logic       data_valid, parity_error, frame_error, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;

  uart_rx #(.DIV(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .data_length  (data_length),
    .parity_type  (parity_type),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_valid) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
    end
  end

  initial begin
    #800000;
    $display("FAIL timeout: simulation did not reach the end (got running, need finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input logic glitch);
    rx_in = v;
    if (glitch) begin
      wait_clk(28);
      rx_in = ~v;
      wait_clk(DIV);
      rx_in = v;
      wait_clk(BIT - 28 - DIV);
    end else begin
      wait_clk(BIT);
    end
  endtask

  // Sends one frame and checks it against what a UART frame of these fields must decode to.
  task automatic send_frame(input string tag, input logic [7:0] d, input logic len8,
                            input logic [1:0] pt, input logic flip_par, input logic stop,
                            input logic flip_cfg, input int glitch_bit);
    int n, ones, p0, t0, lat, exp_lat;
    logic [7:0] dm;
    logic pbit_ok, pbit;
    n  = len8 ? 8 : 7;
    dm = len8 ? d : {1'b0, d[6:0]};
    ones = 0;
    for (int i = 0; i < n; i++) ones += dm[i];
    // even: bit makes total ones even; odd: makes it odd
    pbit_ok = pt[0] ? ((ones % 2) == 0) : ((ones % 2) == 1);
    pbit    = pbit_ok ^ flip_par;

    @(negedge clk);
    data_length = len8;
    parity_type = pt;
    p0 = pulse_cnt;
    t0 = cyc;
    drive_bit(1'b0, 1'b0);
    if (flip_cfg) begin
      data_length = ~data_length;
      parity_type = ~parity_type;
    end
    for (int i = 0; i < n; i++) drive_bit(d[i], i == glitch_bit);
    if (pt != 2'b00) drive_bit(pbit, 1'b0);
    drive_bit(stop, 1'b0);

    exp_lat = BIT * (n + ((pt != 2'b00) ? 1 : 0)) + BIT + BIT / 2;
    lat = last_pulse_cyc - t0;
    check({tag, " pulses"}, pulse_cnt - p0, 1);
    check({tag, " data"}, {24'd0, data_out}, {24'd0, dm});
    check({tag, " perr"}, {31'd0, parity_error}, {31'd0, (pt != 2'b00) && flip_par});
    check({tag, " ferr"}, {31'd0, frame_error}, {31'd0, ~stop});
    check({tag, " latency_ok"}, {31'd0, (lat >= exp_lat - 2) && (lat <= exp_lat + 2 * DIV + 4)}, 1);
  endtask

  initial begin
    int p0;
    logic [7:0] rd;
    logic rlen, rfp, rstop, rflip;
    logic [1:0] rpt;

    wait_clk(3);
    check("rst data_out", {24'd0, data_out}, 0);
    check("rst valid", {31'd0, data_valid}, 0);
    check("rst busy", {31'd0, busy}, 0);
    check("rst perr", {31'd0, parity_error}, 0);
    check("rst ferr", {31'd0, frame_error}, 0);
    rst = 1'b0;
    wait_clk(10);

    send_frame("even_ok", 8'hA5, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, -1);
    send_frame("even_bad", 8'hA5, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, -1);
    send_frame("odd01_7b", 8'h35, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, -1);
    send_frame("odd11_7b", 8'h35, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, -1);

    // Stop bit low, then line held low (break): exactly one frame, no extras.
    send_frame("break", 8'hFF, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    p0 = pulse_cnt;
    wait_clk(3 * BIT);
    check("break no_extra", pulse_cnt - p0, 0);
    check("break busy", {31'd0, busy}, 0);
    rx_in = 1'b1;
    wait_clk(BIT);
    send_frame("after_break", 8'h5A, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, -1);

    // False start: 3 ticks low.
    p0 = pulse_cnt;
    rx_in = 1'b0;
    wait_clk(3 * DIV);
    rx_in = 1'b1;
    wait_clk(BIT);
    check("false_start pulses", pulse_cnt - p0, 0);
    check("false_start busy", {31'd0, busy}, 0);

`ifdef UART_RX_MAJORITY_EN
    send_frame("glitch", 8'h96, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 3);
`endif

    // Reset during data bit 4.
    p0 = pulse_cnt;
    data_length = 1'b1;
    parity_type = 2'b00;
    rd = 8'hC3;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rd[i], 1'b0);
    rx_in = rd[4];
    wait_clk(BIT / 2);
    rst = 1'b1;
    wait_clk(2);
    check("midrst data_out", {24'd0, data_out}, 0);
    check("midrst valid", {31'd0, data_valid}, 0);
    check("midrst perr", {31'd0, parity_error}, 0);
    check("midrst ferr", {31'd0, frame_error}, 0);
    check("midrst busy", {31'd0, busy}, 0);
    rx_in = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(2 * BIT);
    check("midrst no_pulse", pulse_cnt - p0, 0);
    send_frame("post_rst", 8'h3C, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, -1);

    send_frame("b2b_1", 8'h01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, -1);
    send_frame("b2b_2", 8'h80, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, -1);

    for (int k = 0; k < 20; k++) begin
      rd    = 8'($urandom);
      rlen  = 1'($urandom);
      rpt   = 2'($urandom);
      rfp   = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 4) != 0);
      rflip = 1'($urandom);
      send_frame($sformatf("rand%0d", k), rd, rlen, rpt, rfp, rstop, rflip, -1);
      if (!rstop) begin
        rx_in = 1'b1;
        wait_clk(BIT);
      end
      if ($urandom_range(0, 2) == 0) wait_clk($urandom_range(1, 2 * BIT));
    end

    wait_clk(BIT);
    check("final busy", {31'd0, busy}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
